// File: rtl/stopwatch_timer_dp.sv
// stopwatch_timer_dp: run-gated centisecond divider feeding a single-cycle
// msec/sec/min/hour chain that counts up (stopwatch) or down (countdown timer),
// with preset load, a one-cycle done pulse at zero and optional lap capture.
// Define STOPWATCH_LAP_EN to build the lap-capture registers; otherwise the
// lap input is ignored and every lap output is tied to 0.
module stopwatch_timer_dp #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic       mode,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       lap,
  output logic [6:0] msec,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [4:0] hour,
  output logic [6:0] lap_msec,
  output logic [6:0] lap_sec,
  output logic [6:0] lap_min,
  output logic [4:0] lap_hour,
  output logic       lap_valid,
  output logic       done
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [4:0]       HOUR_LAST = 5'(HOUR_MAX - 1);

  logic [DIV_W-1:0] div_reg;
  logic             expired_reg;
  logic [6:0]       msec_reg, sec_reg, min_reg;
  logic [4:0]       hour_reg;
  logic             done_reg;

  logic             tick;
  logic [6:0]       msec_next, sec_next, min_next;
  logic [4:0]       hour_next;
  logic             expire_hit;
  logic [6:0]       sec_preset, min_preset;
  logic [4:0]       hour_preset;

  // Divider terminal count; expired freezes the divider so no further ticks arrive.
  always_comb begin
    tick = run & ~expired_reg & (div_reg == DIV_LAST);
  end

  // Whole-chain next value from the current registers so every field moves on the same edge.
  always_comb begin
    msec_next  = msec_reg;
    sec_next   = sec_reg;
    min_next   = min_reg;
    hour_next  = hour_reg;
    expire_hit = 1'b0;
    if (!mode) begin
      msec_next = (msec_reg == 7'd99) ? 7'd0 : msec_reg + 7'd1;
      if (msec_reg == 7'd99) begin
        sec_next = (sec_reg == 7'd59) ? 7'd0 : sec_reg + 7'd1;
        if (sec_reg == 7'd59) begin
          min_next = (min_reg == 7'd59) ? 7'd0 : min_reg + 7'd1;
          if (min_reg == 7'd59) begin
            // Full-day rollover wraps silently.
            hour_next = (hour_reg == HOUR_LAST) ? 5'd0 : hour_reg + 5'd1;
          end
        end
      end
    end else if ((msec_reg == 7'd0) && (sec_reg == 7'd0) &&
                 (min_reg == 7'd0) && (hour_reg == 5'd0)) begin
      // Countdown already at zero: hold and flag expiry.
      expire_hit = 1'b1;
    end else begin
      msec_next = (msec_reg == 7'd0) ? 7'd99 : msec_reg - 7'd1;
      if (msec_reg == 7'd0) begin
        sec_next = (sec_reg == 7'd0) ? 7'd59 : sec_reg - 7'd1;
        if (sec_reg == 7'd0) begin
          min_next = (min_reg == 7'd0) ? 7'd59 : min_reg - 7'd1;
          if (min_reg == 7'd0) begin
            // Non-zero overall, so hour is non-zero here.
            hour_next = hour_reg - 5'd1;
          end
        end
      end
    end
  end

  // Preset saturation to the legal field ranges.
  always_comb begin
    sec_preset  = (load_sec > 6'd59) ? 7'd59 : {1'b0, load_sec};
    min_preset  = (load_min > 6'd59) ? 7'd59 : {1'b0, load_min};
    hour_preset = (load_hour > HOUR_LAST) ? HOUR_LAST : load_hour;
  end

  // Divider, counters, expired flag and done pulse with clear > load > tick priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg     <= '0;
      expired_reg <= 1'b0;
      msec_reg    <= 7'd0;
      sec_reg     <= 7'd0;
      min_reg     <= 7'd0;
      hour_reg    <= 5'd0;
      done_reg    <= 1'b0;
    end else if (clear) begin
      div_reg     <= '0;
      expired_reg <= 1'b0;
      msec_reg    <= 7'd0;
      sec_reg     <= 7'd0;
      min_reg     <= 7'd0;
      hour_reg    <= 5'd0;
      done_reg    <= 1'b0;
    end else if (load) begin
      // Any tick landing on this edge is dropped.
      div_reg     <= '0;
      expired_reg <= 1'b0;
      msec_reg    <= 7'd0;
      sec_reg     <= sec_preset;
      min_reg     <= min_preset;
      hour_reg    <= hour_preset;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (run && !expired_reg) begin
        div_reg <= tick ? '0 : div_reg + DIV_W'(1);
      end
      if (tick) begin
        msec_reg <= msec_next;
        sec_reg  <= sec_next;
        min_reg  <= min_next;
        hour_reg <= hour_next;
        if (expire_hit) begin
          done_reg    <= 1'b1;
          expired_reg <= 1'b1;
        end
      end
      // Switching to count-up re-arms the chain; expire_hit is never set in up mode.
      if (!mode) begin
        expired_reg <= 1'b0;
      end
    end
  end

  assign msec = msec_reg;
  assign sec  = sec_reg;
  assign min  = min_reg;
  assign hour = hour_reg;
  assign done = done_reg;

`ifdef STOPWATCH_LAP_EN
  logic [6:0] lap_msec_reg, lap_sec_reg, lap_min_reg;
  logic [4:0] lap_hour_reg;
  logic       lap_valid_reg;

  // Lap snapshot of the pre-update time; clear overrides a coincident lap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_msec_reg  <= 7'd0;
      lap_sec_reg   <= 7'd0;
      lap_min_reg   <= 7'd0;
      lap_hour_reg  <= 5'd0;
      lap_valid_reg <= 1'b0;
    end else if (clear) begin
      lap_msec_reg  <= 7'd0;
      lap_sec_reg   <= 7'd0;
      lap_min_reg   <= 7'd0;
      lap_hour_reg  <= 5'd0;
      lap_valid_reg <= 1'b0;
    end else if (lap) begin
      lap_msec_reg  <= msec_reg;
      lap_sec_reg   <= sec_reg;
      lap_min_reg   <= min_reg;
      lap_hour_reg  <= hour_reg;
      lap_valid_reg <= 1'b1;
    end
  end

  assign lap_msec  = lap_msec_reg;
  assign lap_sec   = lap_sec_reg;
  assign lap_min   = lap_min_reg;
  assign lap_hour  = lap_hour_reg;
  assign lap_valid = lap_valid_reg;
`else
  logic unused_lap;
  assign unused_lap = lap;

  assign lap_msec  = 7'd0;
  assign lap_sec   = 7'd0;
  assign lap_min   = 7'd0;
  assign lap_hour  = 5'd0;
  assign lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer_dp.sv
// tb_stopwatch_timer_dp: directed test of stopwatch_timer_dp with DIV=10.
// Lap expectations follow STOPWATCH_LAP_EN the same way the design does.
module tb_stopwatch_timer_dp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hour = 5'd0;
  logic [5:0] load_min = 6'd0;
  logic [5:0] load_sec = 6'd0;
  logic       lap = 1'b0;
  logic [6:0] msec, sec, min, lap_msec, lap_sec, lap_min;
  logic [4:0] hour, lap_hour;
  logic       lap_valid, done;

  int total = 0;
  int bad   = 0;

  stopwatch_timer_dp #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .HOUR_MAX(24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clear    (clear),
    .mode     (mode),
    .load     (load),
    .load_hour(load_hour),
    .load_min (load_min),
    .load_sec (load_sec),
    .lap      (lap),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .lap_msec (lap_msec),
    .lap_sec  (lap_sec),
    .lap_min  (lap_min),
    .lap_hour (lap_hour),
    .lap_valid(lap_valid),
    .done     (done)
  );

  always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  // Pack h:m:s.cs in the same layout as the observed fields.
  function automatic logic [31:0] hms(input int h, input int m, input int s, input int cs);
    return {6'd0, 5'(h), 7'(m), 7'(s), 7'(cs)};
  endfunction

  function automatic logic [31:0] cur_time();
    return {6'd0, hour, min, sec, msec};
  endfunction

  function automatic logic [31:0] cur_lap();
    return {6'd0, lap_hour, lap_min, lap_sec, lap_msec};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance n rising edges, return on the following falling edge.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_hour = 5'(h);
    load_min  = 6'(m);
    load_sec  = 6'(s);
    load = 1'b1;
    clocks(1);
    load = 1'b0;
  endtask

  logic seen;

  initial begin
    // Reset state
    clocks(2);
    check("rst_time", cur_time(), 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_lapv", {31'd0, lap_valid}, 32'd0);
    rst = 1'b0;

    // First tick after 10 clocks, first second after 1000
    run = 1'b1;
    clocks(10);
    check("first_tick", cur_time(), hms(0, 0, 0, 1));
    clocks(990);
    check("one_sec", cur_time(), hms(0, 0, 1, 0));

    // Pause at divider count 5, resume: tick exactly 5 clocks later
    clocks(5);
    run = 1'b0;
    clocks(37);
    check("pause_hold", cur_time(), hms(0, 0, 1, 0));
    run = 1'b1;
    clocks(4);
    check("resume_4", cur_time(), hms(0, 0, 1, 0));
    clocks(1);
    check("resume_5", cur_time(), hms(0, 0, 1, 1));

    // Up rollover is silent
    do_load(23, 59, 59);
    check("load_2359", cur_time(), hms(23, 59, 59, 0));
    clocks(990);
    check("roll_99", cur_time(), hms(23, 59, 59, 99));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clocks(1);
      if (done) seen = 1'b1;
    end
    check("roll_zero", cur_time(), hms(0, 0, 0, 0));
    check("roll_nodone", {31'd0, seen}, 32'd0);

    // Saturating load with a coincident tick (divider at 9)
    clocks(9);
    do_load(30, 10, 63);
    check("sat_load", cur_time(), hms(23, 10, 59, 0));

    // clear beats load
    clear = 1'b1;
    do_load(5, 5, 5);
    clear = 1'b0;
    check("clr_vs_load", cur_time(), 32'd0);

    // Countdown to expiry
    mode = 1'b1;
    do_load(0, 0, 1);
    check("cd_load", cur_time(), hms(0, 0, 1, 0));
    clocks(10);
    check("cd_first", cur_time(), hms(0, 0, 0, 99));
    clocks(990);
    check("cd_zero", cur_time(), 32'd0);
    check("cd_nodone", {31'd0, done}, 32'd0);
    clocks(9);
    check("cd_pre", {31'd0, done}, 32'd0);
    clocks(1);
    check("cd_done", {31'd0, done}, 32'd1);
    clocks(1);
    check("cd_done_1cyc", {31'd0, done}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      clocks(1);
      if (done) seen = 1'b1;
    end
    check("cd_hold", cur_time(), 32'd0);
    check("cd_hold_done", {31'd0, seen}, 32'd0);

    // mode back to up re-arms: one edge clears expiry, then 10 to the tick
    mode = 1'b0;
    clocks(10);
    check("rearm_10", cur_time(), 32'd0);
    clocks(1);
    check("rearm_11", cur_time(), hms(0, 0, 0, 1));

    // Lap capture at 0:00:02.37
    clear = 1'b1;
    clocks(1);
    clear = 1'b0;
    clocks(2370);
    check("lap_pre", cur_time(), hms(0, 0, 2, 37));
    lap = 1'b1;
    clocks(1);
    lap = 1'b0;
    check("lap_val", cur_lap(), LAP_ON ? hms(0, 0, 2, 37) : 32'd0);
    check("lap_valid", {31'd0, lap_valid}, {31'd0, LAP_ON});
    clocks(19);
    check("lap_run", cur_time(), hms(0, 0, 2, 39));
    check("lap_keep", cur_lap(), LAP_ON ? hms(0, 0, 2, 37) : 32'd0);

    // clear with coincident lap: clear wins
    clear = 1'b1;
    lap = 1'b1;
    clocks(1);
    clear = 1'b0;
    lap = 1'b0;
    check("clr_lap_val", cur_lap(), 32'd0);
    check("clr_lap_valid", {31'd0, lap_valid}, 32'd0);
    check("clr_time", cur_time(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
